pc_fetch_unit: RTL and testbench

//  Program counter and next-address logic feeding InstructionMemory.address (12b).

---
 rtl/cpu_pkg.sv | 17 +
 rtl/pc_return_stack.sv | 91 +++++++++
 rtl/pc_fetch_unit.sv | 80 ++++++++
 tb/tb_pc_fetch_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU fetch types: PC width, branch offset type and next-PC source select.
package cpu_pkg;

  localparam int unsigned ADDR_W = 12;

  typedef logic [ADDR_W-1:0] pc_t;
  typedef logic signed [7:0] br_off_t;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_JMP,
    SEL_JSB,
    SEL_RET
  } next_pc_sel_e;

endpackage

// File: rtl/pc_return_stack.sv
// Hardware return-address stack for JSB/RET.
// PC_STACK_GUARD_EN: refuse push when full / pop when empty and raise sticky flags; otherwise circular.
module pc_return_stack import cpu_pkg::*; #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = ADDR_W
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [DATA_W-1:0]      push_data_i,
  output logic [DATA_W-1:0]      pop_data_o,
  output logic                   pop_valid_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overflow_o,
  output logic                   underflow_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  sp_q, sp_d, spPrev;
  logic [PTR_W:0]    level_q, level_d;
  logic              full, empty, doPush, doPop;

  assign full   = (level_q == FULL_LEVEL);
  assign empty  = (level_q == '0);
  assign spPrev = sp_q - 1'b1;

`ifdef PC_STACK_GUARD_EN
  assign doPush      = push_i && !full;
  assign doPop       = pop_i && !empty;
  assign pop_valid_o = !empty;
`else
  assign doPush      = push_i;
  assign doPop       = pop_i;
  assign pop_valid_o = 1'b1;
`endif

  // Pointer always moves on an accepted push/pop; level saturates so it never reports beyond the array.
  always_comb begin
    sp_d    = sp_q;
    level_d = level_q;
    if (doPush) begin
      sp_d = sp_q + 1'b1;
      if (!full) level_d = level_q + 1'b1;
    end else if (doPop) begin
      sp_d = spPrev;
      if (!empty) level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sp_q    <= '0;
      level_q <= '0;
    end else begin
      sp_q    <= sp_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[sp_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[spPrev];
  assign level_o    = level_q;

`ifdef PC_STACK_GUARD_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_i && full)  overflow_q  <= 1'b1;
      if (pop_i && empty) underflow_q <= 1'b1;
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
`else
  assign overflow_o  = 1'b0;
  assign underflow_o = 1'b0;
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and next-address selection feeding instruction memory.
// Macro PC_STACK_GUARD_EN selects the guarded return stack; default build uses a circular stack.
module pc_fetch_unit import cpu_pkg::*; #(
  parameter int unsigned STACK_DEPTH = 8,
  parameter pc_t         RESET_PC    = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         stall_i,
  input  logic                         branch_taken_i,
  input  br_off_t                      branch_offset_i,
  input  logic                         jump_en_i,
  input  logic                         jsb_en_i,
  input  logic                         ret_en_i,
  input  pc_t                          target_addr_i,
  output pc_t                          address_o,
  output logic [$clog2(STACK_DEPTH):0] stack_level_o,
  output logic                         stack_overflow_o,
  output logic                         stack_underflow_o
);

  pc_t          pc_q, pc_d;
  pc_t          pcPlusOne, branchTarget, retTarget, popData;
  logic         popValid, push, pop;
  next_pc_sel_e sel;

  always_comb begin
    sel = SEL_SEQ;
    if (ret_en_i)            sel = SEL_RET;
    else if (jsb_en_i)       sel = SEL_JSB;
    else if (jump_en_i)      sel = SEL_JMP;
    else if (branch_taken_i) sel = SEL_BR;
  end

  assign pcPlusOne    = pc_q + 1'b1;
  assign branchTarget = pcPlusOne + {{(ADDR_W-8){branch_offset_i[7]}}, branch_offset_i};

  // A RET the stack refuses (guarded and empty) falls through to the next sequential address.
  assign retTarget = popValid ? popData : pcPlusOne;

  assign push = !stall_i && (sel == SEL_JSB);
  assign pop  = !stall_i && (sel == SEL_RET);

  always_comb begin
    pc_d = pc_q;
    if (!stall_i) begin
      unique case (sel)
        SEL_BR:  pc_d = branchTarget;
        SEL_JMP: pc_d = target_addr_i;
        SEL_JSB: pc_d = target_addr_i;
        SEL_RET: pc_d = retTarget;
        default: pc_d = pcPlusOne;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pc_q <= RESET_PC;
    else         pc_q <= pc_d;
  end

  assign address_o = pc_q;

  pc_return_stack #(
    .DEPTH  (STACK_DEPTH),
    .DATA_W (ADDR_W)
  ) u_stack (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (pcPlusOne),
    .pop_data_o  (popData),
    .pop_valid_o (popValid),
    .level_o     (stack_level_o),
    .overflow_o  (stack_overflow_o),
    .underflow_o (stack_underflow_o)
  );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit; expectations follow PC_STACK_GUARD_EN when defined.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branchTaken;
  logic [7:0]  branchOffset;
  logic        jumpEn;
  logic        jsbEn;
  logic        retEn;
  logic [11:0] targetAddr;
  logic [11:0] address;
  logic [3:0]  stackLevel;
  logic        overflow;
  logic        underflow;

  int assertCount = 0;
  int failCount   = 0;

`ifdef PC_STACK_GUARD_EN
  localparam logic EXP_FLAG = 1'b1;
`else
  localparam logic EXP_FLAG = 1'b0;
`endif

  pc_fetch_unit dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .stall_i           (stall),
    .branch_taken_i    (branchTaken),
    .branch_offset_i   (branchOffset),
    .jump_en_i         (jumpEn),
    .jsb_en_i          (jsbEn),
    .ret_en_i          (retEn),
    .target_addr_i     (targetAddr),
    .address_o         (address),
    .stack_level_o     (stackLevel),
    .stack_overflow_o  (overflow),
    .stack_underflow_o (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    stall        = 1'b0;
    branchTaken  = 1'b0;
    branchOffset = 8'h00;
    jumpEn       = 1'b0;
    jsbEn        = 1'b0;
    retEn        = 1'b0;
    targetAddr   = 12'd0;
  endtask

  task automatic gotoPc(input logic [11:0] a);
    jumpEn     = 1'b1;
    targetAddr = a;
    tick();
    jumpEn     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clearInputs();
    #12;
    assertCount++;
    if (address !== 12'd0) begin failCount++; $display("[TB] FAIL reset_addr: got %0d expected 0", address); end
    assertCount++;
    if (stackLevel !== 4'd0) begin failCount++; $display("[TB] FAIL reset_level: got %0d expected 0", stackLevel); end
    assertCount++;
    if ({overflow, underflow} !== 2'b00) begin failCount++; $display("[TB] FAIL reset_flags: got %b expected 00", {overflow, underflow}); end
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      assertCount++;
      if (address !== 12'(i)) begin failCount++; $display("[TB] FAIL seq_run: got %0d expected %0d", address, i); end
    end
    rst_n = 1'b0;
    #1;
    assertCount++;
    if (address !== 12'd0) begin failCount++; $display("[TB] FAIL async_reset: got %0d expected 0", address); end
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_branch();
    gotoPc(12'd25);
    branchTaken = 1'b1; branchOffset = 8'h03;
    tick();
    assertCount++;
    if (address !== 12'd29) begin failCount++; $display("[TB] FAIL branch_fwd: got %0d expected 29", address); end
    branchTaken = 1'b0;
    gotoPc(12'd30);
    branchTaken = 1'b1; branchOffset = 8'hFF;
    tick();
    assertCount++;
    if (address !== 12'd30) begin failCount++; $display("[TB] FAIL branch_self: got %0d expected 30", address); end
    branchTaken = 1'b0;
    gotoPc(12'd100);
    jumpEn = 1'b1; targetAddr = 12'd200; branchTaken = 1'b1; branchOffset = 8'h05;
    tick();
    assertCount++;
    if (address !== 12'd200) begin failCount++; $display("[TB] FAIL jump_over_branch: got %0d expected 200", address); end
    clearInputs();
  endtask

  task automatic test_jsb_ret();
    gotoPc(12'd40);
    jsbEn = 1'b1; targetAddr = 12'd45;
    tick();
    jsbEn = 1'b0;
    assertCount++;
    if (address !== 12'd45 || stackLevel !== 4'd1) begin failCount++; $display("[TB] FAIL jsb: got addr %0d level %0d expected 45 1", address, stackLevel); end
    retEn = 1'b1;
    tick();
    retEn = 1'b0;
    assertCount++;
    if (address !== 12'd41 || stackLevel !== 4'd0) begin failCount++; $display("[TB] FAIL ret: got addr %0d level %0d expected 41 0", address, stackLevel); end
  endtask

  task automatic test_wrap();
    gotoPc(12'd4095);
    tick();
    assertCount++;
    if (address !== 12'd0) begin failCount++; $display("[TB] FAIL pc_wrap: got %0d expected 0", address); end
    gotoPc(12'd2);
    branchTaken = 1'b1; branchOffset = 8'h80;
    tick();
    branchTaken = 1'b0;
    assertCount++;
    if (address !== 12'd3971) begin failCount++; $display("[TB] FAIL branch_neg_wrap: got %0d expected 3971", address); end
  endtask

  task automatic test_stall();
    gotoPc(12'd60);
    stall = 1'b1; jsbEn = 1'b1; targetAddr = 12'd70;
    for (int i = 0; i < 3; i++) begin
      tick();
      assertCount++;
      if (address !== 12'd60 || stackLevel !== 4'd0) begin failCount++; $display("[TB] FAIL stall_hold: got addr %0d level %0d expected 60 0", address, stackLevel); end
    end
    stall = 1'b0;
    tick();
    jsbEn = 1'b0;
    assertCount++;
    if (address !== 12'd70 || stackLevel !== 4'd1) begin failCount++; $display("[TB] FAIL stall_release: got addr %0d level %0d expected 70 1", address, stackLevel); end
    retEn = 1'b1;
    tick();
    retEn = 1'b0;
    assertCount++;
    if (address !== 12'd61 || stackLevel !== 4'd0) begin failCount++; $display("[TB] FAIL stall_ret: got addr %0d level %0d expected 61 0", address, stackLevel); end
  endtask

  task automatic test_stack_limits();
    int retExp [9];
`ifdef PC_STACK_GUARD_EN
    retExp = '{197, 181, 165, 149, 133, 117, 101, 51, 52};
`else
    retExp = '{213, 197, 181, 165, 149, 133, 117, 101, 213};
`endif
    gotoPc(12'd50);
    jsbEn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      targetAddr = 12'(100 + 16 * i);
      tick();
      assertCount++;
      if (address !== 12'(100 + 16 * i) || stackLevel !== 4'(i + 1)) begin failCount++; $display("[TB] FAIL jsb_nest: got addr %0d level %0d expected %0d %0d", address, stackLevel, 100 + 16 * i, i + 1); end
    end
    targetAddr = 12'd500;
    tick();
    jsbEn = 1'b0;
    assertCount++;
    if (address !== 12'd500 || stackLevel !== 4'd8 || overflow !== EXP_FLAG) begin failCount++; $display("[TB] FAIL jsb_full: got addr %0d level %0d ovf %b expected 500 8 %b", address, stackLevel, overflow, EXP_FLAG); end
    retEn = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      assertCount++;
      if (address !== 12'(retExp[i]) || stackLevel !== 4'((i < 8) ? 7 - i : 0)) begin failCount++; $display("[TB] FAIL ret_unwind: got addr %0d level %0d expected %0d %0d", address, stackLevel, retExp[i], (i < 8) ? 7 - i : 0); end
    end
    retEn = 1'b0;
    assertCount++;
    if (underflow !== EXP_FLAG || overflow !== EXP_FLAG) begin failCount++; $display("[TB] FAIL flags_after_unwind: got ovf %b unf %b expected %b %b", overflow, underflow, EXP_FLAG, EXP_FLAG); end
    tick();
    assertCount++;
    if (underflow !== EXP_FLAG || overflow !== EXP_FLAG) begin failCount++; $display("[TB] FAIL flags_sticky: got ovf %b unf %b expected %b %b", overflow, underflow, EXP_FLAG, EXP_FLAG); end
  endtask

  task automatic test_back_to_back();
    gotoPc(12'd300);
    jsbEn = 1'b1; targetAddr = 12'd400;
    tick();
    assertCount++;
    if (address !== 12'd400 || stackLevel !== 4'd1) begin failCount++; $display("[TB] FAIL b2b_jsb: got addr %0d level %0d expected 400 1", address, stackLevel); end
    retEn = 1'b1; targetAddr = 12'd500;
    tick();
    retEn = 1'b0;
    assertCount++;
    if (address !== 12'd301 || stackLevel !== 4'd0) begin failCount++; $display("[TB] FAIL ret_beats_jsb: got addr %0d level %0d expected 301 0", address, stackLevel); end
    targetAddr = 12'd600;
    tick();
    targetAddr = 12'd700;
    tick();
    jsbEn = 1'b0;
    assertCount++;
    if (address !== 12'd700 || stackLevel !== 4'd2) begin failCount++; $display("[TB] FAIL b2b_jsb2: got addr %0d level %0d expected 700 2", address, stackLevel); end
    retEn = 1'b1;
    tick();
    assertCount++;
    if (address !== 12'd601 || stackLevel !== 4'd1) begin failCount++; $display("[TB] FAIL b2b_ret1: got addr %0d level %0d expected 601 1", address, stackLevel); end
    tick();
    retEn = 1'b0;
    assertCount++;
    if (address !== 12'd302 || stackLevel !== 4'd0) begin failCount++; $display("[TB] FAIL b2b_ret2: got addr %0d level %0d expected 302 0", address, stackLevel); end
    jsbEn = 1'b1; targetAddr = 12'd800;
    tick();
    jsbEn = 1'b0;
    rst_n = 1'b0;
    #1;
    assertCount++;
    if (address !== 12'd0 || stackLevel !== 4'd0 || {overflow, underflow} !== 2'b00) begin failCount++; $display("[TB] FAIL reset_after_push: got addr %0d level %0d flags %b expected 0 0 00", address, stackLevel, {overflow, underflow}); end
    #2;
    rst_n = 1'b1;
    tick();
    assertCount++;
    if (address !== 12'd1) begin failCount++; $display("[TB] FAIL restart_after_reset: got %0d expected 1", address); end
  endtask

  initial begin
    $display("[TB] pc_fetch_unit directed test start");
    test_reset();
    test_branch();
    test_jsb_ret();
    test_wrap();
    test_stall();
    test_stack_limits();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
